// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window,
// emitting only fully interior windows as zero-extended signed taps.
module sobel_window_gen #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int TAP_W = PIX_W + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PIX_W-1:0]        in_pix,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [TAP_W-1:0] Ai00,
  output logic signed [TAP_W-1:0] Ai01,
  output logic signed [TAP_W-1:0] Ai02,
  output logic signed [TAP_W-1:0] Ai10,
  output logic signed [TAP_W-1:0] Ai11,
  output logic signed [TAP_W-1:0] Ai12,
  output logic signed [TAP_W-1:0] Ai20,
  output logic signed [TAP_W-1:0] Ai21,
  output logic signed [TAP_W-1:0] Ai22,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]    col_r, col_next_s;
  logic [RW-1:0]    row_r, row_next_s;
  logic             accept_s, win_s, last_s;
  logic [PIX_W-1:0] lb0_r [IMG_W];
  logic [PIX_W-1:0] lb1_r [IMG_W];
  logic [PIX_W-1:0] lb0_rd_s, lb1_rd_s;
  logic [PIX_W-1:0] win_r [3][3];

  assign in_ready = !out_valid || out_ready;
  assign accept_s = in_valid && in_ready;
  assign lb0_rd_s = lb0_r[col_r];
  assign lb1_rd_s = lb1_r[col_r];

  // Raster position of the next pixel and whether it completes an interior window.
  always_comb begin
    col_next_s = col_r;
    row_next_s = row_r;
    if (col_r == COL_LAST) begin
      col_next_s = {CW{1'b0}};
      if (row_r == ROW_LAST) begin
        row_next_s = {RW{1'b0}};
      end else begin
        row_next_s = row_r + RW'(1);
      end
    end else begin
      col_next_s = col_r + CW'(1);
    end
    win_s  = (row_r >= RW'(2)) && (col_r >= CW'(2));
    last_s = (row_r == ROW_LAST) && (col_r == COL_LAST);
  end

  // Position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
    end else if (accept_s) begin
      col_r <= col_next_s;
      row_r <= row_next_s;
    end else begin
      col_r <= col_r;
      row_r <= row_r;
    end
  end

  // Line buffers carry no reset; the valid rule keeps stale rows hidden.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb0_r[col_r] <= lb1_rd_s;
      lb1_r[col_r] <= in_pix;
    end
  end

  // Shift window: new right column is {row r-2, row r-1, current pixel}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_r[i][j] <= {PIX_W{1'b0}};
        end
      end
    end else if (accept_s) begin
      for (int i = 0; i < 3; i++) begin
        win_r[i][0] <= win_r[i][1];
        win_r[i][1] <= win_r[i][2];
      end
      win_r[0][2] <= lb0_rd_s;
      win_r[1][2] <= lb1_rd_s;
      win_r[2][2] <= in_pix;
    end
  end

  // Single-entry output register handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept_s) begin
      out_valid <= win_s;
      out_last  <= win_s && last_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= out_valid;
      out_last  <= out_last;
    end
  end

  assign Ai00 = TAP_W'(win_r[0][0]);
  assign Ai01 = TAP_W'(win_r[0][1]);
  assign Ai02 = TAP_W'(win_r[0][2]);
  assign Ai10 = TAP_W'(win_r[1][0]);
  assign Ai11 = TAP_W'(win_r[1][1]);
  assign Ai12 = TAP_W'(win_r[1][2]);
  assign Ai20 = TAP_W'(win_r[2][0]);
  assign Ai21 = TAP_W'(win_r[2][1]);
  assign Ai22 = TAP_W'(win_r[2][2]);

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator feeding the Sobel 3x3 MAC stage. It accepts raster-ordered pixels one per handshake and buffers the two previous image rows in line buffers. For every pixel that completes a full 3x3 neighbourhood, it presents nine registered taps whose names and signed widths match the MAC's `Ai` operands. Only fully interior windows are emitted: no padding, no border replication.

## Interface
- `PIX_W`, 8: unsigned input pixel width.
- `IMG_W`, 640: pixels per row, minimum 3.
- `IMG_H`, 480: rows per frame, minimum 3.
- `TAP_W`, PIX_W+1: signed tap width. This equals the MAC's `Ai_width`.
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_pix`  in  PIX_W: raster-order pixel, unsigned.
- `in_valid`  in  1: `in_pix` is valid.
- `in_ready`  out  1: block can accept a pixel. A pixel transfers when `in_valid && in_ready`.
- `Ai00`..`Ai22`  out  TAP_W each, signed: window taps. Row index is first, column index is second; `Ai00` is the oldest (top-left) pixel and `Ai22` is the newest.
- `out_valid`  out  1: taps hold a valid window.
- `out_ready`  in  1: downstream accepts the window.
- `out_last`  out  1: the current window is the last window of the frame.

## Operation
- **Counters.**
  - `col` runs 0..IMG_W-1 and `row` runs 0..IMG_H-1, tracking the position of the next accepted pixel.
  - On every accept, `col` increments. At `col == IMG_W-1`, `col` wraps to 0 and `row` increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and the next pixel starts a new frame. There is no gap and no start-of-frame input.
- **Line buffers.**
  - Two buffers, each IMG_W deep x PIX_W, indexed by `col`.
  - On accept at column c: `lb1[c]` moves into `lb0[c]`, and `in_pix` is written into `lb1[c]`. `lb0` holds row r-2 and `lb1` holds row r-1.
  - Buffer contents are not reset.
- **Shift window.**
  - Three 3-entry column shift registers.
  - Each accept shifts in {`lb0[c]`, `lb1[c]`, `in_pix`} as the new right column.
  - The window shifts across row boundaries without clearing. Stale columns are masked by the valid rule below.
- **Valid rule.** A window is produced on the accept of pixel (r, c) iff r >= 2 and c >= 2. The window is centred at (r-1, c-1).
- **Windows per frame.** (IMG_W-2)*(IMG_H-2).
- **Tap mapping.** `Ai` at row i, column j = pixel(r-2+i, c-2+j), zero-extended to TAP_W. The MSB is always 0, so the MAC sees non-negative operands.
- **`out_last`.** Asserted with the window produced by pixel (IMG_H-1, IMG_W-1).
- **Handshake.**
  - `in_ready = !out_valid || out_ready`. This is a single-entry output register with no bubble on continuous flow.
  - Accepting a pixel that produces no window clears `out_valid`, provided the old window is being consumed in the same cycle.
  - Taps, `out_valid` and `out_last` are stable while `out_valid && !out_ready`.

## Timing
- **Latency.** The window appears on the taps with `out_valid=1` on the rising edge that accepts pixel (r, c), i.e. one cycle after `in_pix` is presented.
- **Throughput.** One pixel per cycle when `out_ready` is held at 1.
- **Reset values.** `out_valid=0`, `out_last=0`, all `Ai*`=0, `col=0`, `row=0`, shift window = 0. `in_ready` reads 1 during and after reset.
- **Reset mid-frame.**
  - Takes effect immediately and asynchronously.
  - The next accepted pixel is treated as (0, 0).
  - No window is emitted until row 2, col 2 of the new frame, so stale line-buffer data is never exposed.
- **Simultaneous handshakes.** Output consume and input accept in the same cycle load the new window (or clear `out_valid`) with no lost or duplicated window.
- **Frame wrap.**
  - The first frame-N+1 pixel may be accepted in the cycle right after the `out_last` window is loaded, as long as `in_ready` is 1.
  - That pixel produces no window.

## Test plan
1. **Basic window.** IMG_W=4, IMG_H=4, pixel = 4r+c, `out_ready=1`. Expected:
   - Exactly 4 windows.
   - The first appears one cycle after pixel value 10 is accepted, with taps 0,1,2 / 4,5,6 / 8,9,10.
   - The last has taps 5,6,7 / 9,10,11 / 13,14,15 and `out_last=1`.
   - `out_valid` is low for all other cycles.
2. **Back-to-back frames.** Same setup, two frames streamed continuously. Expected:
   - 8 windows total.
   - The second frame's first window is again 0,1,2 / 4,5,6 / 8,9,10.
   - No window spans the frame boundary.
3. **Backpressure.** Hold `out_ready=0` for 3 cycles while the first window is presented. Expected:
   - `in_ready=0` for those cycles.
   - Taps stay 0,1,2 / 4,5,6 / 8,9,10.
   - No pixel is lost; the remaining windows match test 1.
4. **Zero extension.** All pixels 255, PIX_W=8. Expected: every tap = 9'h0FF, i.e. signed +255.
5. **Reset mid-frame.** Assert `rst_n=0` after pixel 9, then restart the stream from value 0. Expected:
   - Outputs are 0 during reset.
   - Exactly 4 windows follow, identical to test 1.
6. **Input bubbles.** Random `in_valid` gaps with `out_ready=1`. Expected: the window sequence is identical to test 1.
